mux4_rr_arbiter: RTL and testbench
==================================

# mux4_rr_arbiter

- Round-robin arbiter and sequencer for the 4:1 mux (`mux_g`).
- Four requesters compete for the shared mux output. The block grants exactly one requester at a time and drives the mux select lines `cntrl1`/`cntrl2` for the owner.
- A one-cycle break is inserted on every ownership change, so the select never switches while a grant is asserted.

## Interface
Parameters:
- `MAX_HOLD`, 8: maximum consecutive grant cycles before preemption. Legal range 1..2^CNT_W-1.
- `CNT_W`, 4: width of the hold counter.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `req`  input  4: request vector; `req[i]` belongs to mux input `in(i+1)`.
- `gnt`  output 4: one-hot grant, registered; all zero when nobody owns the mux.
- `cntrl1`  output 1: mux select MSB, registered.
- `cntrl2`  output 1: mux select LSB, registered.
- `out_valid`  output 1: high exactly when `gnt` is non-zero.
- `hold_cnt`  output CNT_W: cycles the current owner has held the grant, saturating at MAX_HOLD.

## Operation
Select mapping, {cntrl1,cntrl2}:
- 00 → in1
- 01 → in2
- 10 → in3
- 11 → in4

The index always equals the owner index.

States:
- IDLE: no grant.
- GRANT: one owner.
- BREAK: one cycle, no grant.

Transitions:
- IDLE → GRANT when `req` is non-zero.
- GRANT → GRANT while the owner's `req` stays high and preemption does not fire.
- GRANT → BREAK when the owner drops `req`, or when preemption fires.
- BREAK → GRANT if any `req` is high, else → IDLE.

Round-robin pick:
- Search starts at `last_owner`+1 (mod 4) and takes the first set `req` bit.
- `last_owner` resets to 3, so requester 0 is first after reset.
- `last_owner` updates on every grant.
- In BREAK, the previous owner is still eligible, but only at lowest priority.

Hold counter:
- Loads 1 on entering GRANT.
- Increments each cycle in GRANT and saturates at MAX_HOLD.
- Cleared in IDLE and BREAK.

Preemption (only with the macro, see Configuration):
- Fires when `hold_cnt` == MAX_HOLD and any other `req` bit is high.
- If no other requester is present, the owner keeps the grant indefinitely and `hold_cnt` stays at MAX_HOLD.

Select behaviour:
- `cntrl1`/`cntrl2` load the new owner index on entry to GRANT.
- They hold their value in BREAK and IDLE, so the mux output is stable and the last selection is retained.

Reset:
- State = IDLE.
- `gnt` = 0000, `cntrl1` = 0, `cntrl2` = 0, `out_valid` = 0, `hold_cnt` = 0, `last_owner` = 3.
- Reset asserted mid-grant drops the grant at the next edge, with no BREAK cycle.

## Timing
- Request to grant from IDLE: `req` sampled high at edge k gives `gnt`/select valid after edge k (1-cycle latency).
- Release: owner `req` low at edge k gives `gnt` = 0 after k (BREAK). The next owner is granted after k+1, so the handover gap is exactly one cycle.
- Preemption: owner granted at edge g. Its `hold_cnt` reaches MAX_HOLD after edge g+MAX_HOLD-1. BREAK follows after edge g+MAX_HOLD if a competitor is present.
- Simultaneous owner release and new requests: BREAK is still inserted; the pick follows the round-robin order.
- A `req` change mid-BREAK is sampled at the BREAK exit edge.
- `gnt` is never multi-hot. `out_valid` == |`gnt` on every cycle.

## Configuration
- `MUX4_ARB_TIMEOUT_EN` defined: MAX_HOLD preemption is active as described above.
- Undefined: no preemption. The owner keeps the grant until its `req` drops. `hold_cnt` still counts and saturates but has no effect.

## Test plan
- Reset then `req`=0000 → `gnt`=0000, {cntrl1,cntrl2}=00, `out_valid`=0 for all cycles.
- `req`=1111 held, each owner drops `req` after 2 grant cycles → grant order 0,1,2,3,0, each grant separated by one BREAK cycle with `gnt`=0000. Select sequence 00,01,10,11,00.
- With macro, MAX_HOLD=8, `req`=0101 held → owner 0 for 8 cycles, BREAK, owner 2 for 8 cycles, BREAK, owner 0 again.
- Without macro, same stimulus → owner 0 holds indefinitely and `hold_cnt` saturates at 8.
- Owner 1 granted, `rst` pulsed for 1 cycle → after that edge `gnt`=0000 and select=00. Next grant with `req`=0010 goes to requester 1 after 1 cycle.
- `req`=0010 only, owner drops and re-raises during BREAK → requester 1 is re-granted after BREAK, select stays 01 throughout.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter and select sequencer for a shared 4:1 mux.
// Exactly one requester owns the mux at a time. A one-cycle break with no grant
// separates every pair of owners, so the select lines never move under a live grant.
// Optional feature: define MUX4_ARB_TIMEOUT_EN to preempt an owner that has held
// the grant for MAX_HOLD cycles while another requester is waiting.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  output logic [3:0]       gnt,
  output logic             cntrl1,
  output logic             cntrl2,
  output logic             out_valid,
  output logic [CNT_W-1:0] hold_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_BREAK = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_HOLD_C = CNT_W'(MAX_HOLD);

  state_t           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [1:0]       pick;
  logic             preempt;

  // First set request after the last owner; the last owner itself comes last.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  // Hold counter advance, saturating at MAX_HOLD.
  function automatic logic [CNT_W-1:0] hold_sat_inc(input logic [CNT_W-1:0] c);
    if (c >= MAX_HOLD_C) hold_sat_inc = MAX_HOLD_C;
    else                 hold_sat_inc = c + CNT_W'(1);
  endfunction

  // Next-state, grant, select and hold-counter decisions.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    hold_d  = hold_q;
    pick    = rr_pick(req, last_q);
`ifdef MUX4_ARB_TIMEOUT_EN
    preempt = (hold_q == MAX_HOLD_C) && (|(req & ~gnt_q));
`else
    preempt = 1'b0;
`endif
    case (state_q)
      S_IDLE, S_BREAK: begin
        if (|req) begin
          state_d = S_GRANT;
          gnt_d   = 4'b0001 << pick;
          sel_d   = pick;
          last_d  = pick;
          hold_d  = CNT_W'(1);
        end else begin
          state_d = S_IDLE;
          gnt_d   = 4'b0000;
          hold_d  = '0;
        end
      end
      S_GRANT: begin
        // The select index always equals the owner index.
        if (!req[sel_q] || preempt) begin
          state_d = S_BREAK;
          gnt_d   = 4'b0000;
          hold_d  = '0;
        end else begin
          hold_d  = hold_sat_inc(hold_q);
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 4'b0000;
        hold_d  = '0;
      end
    endcase
  end

  // State register; reset drops any grant immediately with no break cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      last_q  <= 2'd3;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt       = gnt_q;
  assign cntrl1    = sel_q[1];
  assign cntrl2    = sel_q[0];
  assign out_valid = |gnt_q;
  assign hold_cnt  = hold_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed testbench for mux4_rr_arbiter (default MAX_HOLD=8, CNT_W=4).
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       cntrl1;
  logic       cntrl2;
  logic       out_valid;
  logic [3:0] hold_cnt;

  int n_checks = 0;
  int n_errors = 0;

  mux4_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .cntrl1    (cntrl1),
    .cntrl2    (cntrl2),
    .out_valid (out_valid),
    .hold_cnt  (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] eg, input logic [1:0] es,
                           input logic [3:0] eh);
    check_eq($sformatf("%s.gnt", tag), 32'(gnt), 32'(eg));
    check_eq($sformatf("%s.sel", tag), 32'({cntrl1, cntrl2}), 32'(es));
    check_eq($sformatf("%s.vld", tag), 32'(out_valid), 32'(|eg));
    check_eq($sformatf("%s.hold", tag), 32'(hold_cnt), 32'(eh));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    step();
    step();
    check_out("reset", 4'b0000, 2'b00, 4'd0);
    rst = 1'b0;

    // Idle with no requests
    for (int c = 0; c < 3; c++) begin
      step();
      check_out($sformatf("idle%0d", c), 4'b0000, 2'b00, 4'd0);
    end

    // All request; each owner releases after two grant cycles
    req = 4'b1111;
    step();
    for (int i = 0; i < 5; i++) begin
      int o;
      o = i % 4;
      check_out($sformatf("rr%0d.g1", i), 4'(1 << o), 2'(o), 4'd1);
      step();
      check_out($sformatf("rr%0d.g2", i), 4'(1 << o), 2'(o), 4'd2);
      req = 4'b1111 & ~4'(1 << o);
      step();
      check_out($sformatf("rr%0d.brk", i), 4'b0000, 2'(o), 4'd0);
      req = 4'b1111;
      step();
    end
    req = 4'b0000;
    step();
    check_out("rr.drop", 4'b0000, 2'b01, 4'd0);
    step();
    check_out("rr.idle", 4'b0000, 2'b01, 4'd0);

    // Two competitors with MAX_HOLD = 8
    do_reset();
    req = 4'b0101;
    step();
`ifdef MUX4_ARB_TIMEOUT_EN
    for (int c = 1; c <= 8; c++) begin
      check_out($sformatf("to.o0.%0d", c), 4'b0001, 2'b00, 4'(c));
      step();
    end
    check_out("to.brk1", 4'b0000, 2'b00, 4'd0);
    step();
    for (int c = 1; c <= 8; c++) begin
      check_out($sformatf("to.o2.%0d", c), 4'b0100, 2'b10, 4'(c));
      step();
    end
    check_out("to.brk2", 4'b0000, 2'b10, 4'd0);
    step();
    check_out("to.o0b", 4'b0001, 2'b00, 4'd1);
`else
    for (int c = 1; c <= 12; c++) begin
      check_out($sformatf("nto.o0.%0d", c), 4'b0001, 2'b00, (c > 8) ? 4'd8 : 4'(c));
      step();
    end
`endif

    // Reset pulse while requester 1 owns the mux
    do_reset();
    req = 4'b0010;
    step();
    check_out("rst.own1", 4'b0010, 2'b01, 4'd1);
    rst = 1'b1;
    step();
    check_out("rst.drop", 4'b0000, 2'b00, 4'd0);
    rst = 1'b0;
    step();
    check_out("rst.regnt", 4'b0010, 2'b01, 4'd1);

    // Owner drops then re-raises during the break
    req = 4'b0000;
    step();
    check_out("rr1.brk", 4'b0000, 2'b01, 4'd0);
    req = 4'b0010;
    step();
    check_out("rr1.regnt", 4'b0010, 2'b01, 4'd1);

    // Release with a competitor that sits before the old owner in rotation
    req = 4'b0001;
    step();
    check_out("hand.brk", 4'b0000, 2'b01, 4'd0);
    req = 4'b0011;
    step();
    check_out("hand.o0", 4'b0001, 2'b00, 4'd1);
    req = 4'b0010;
    step();
    check_out("hand.brk2", 4'b0000, 2'b00, 4'd0);
    step();
    check_out("hand.o1", 4'b0010, 2'b01, 4'd1);
    req = 4'b0000;
    step();
    step();
    check_out("end.idle", 4'b0000, 2'b01, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
